mcu_quant_sequencer: RTL
========================

Name: mcu_quant_sequencer

Overview:
- Sequences the shared quantizer through 4:2:0 MCUs: Y0..Y(N-1), then Cb, then Cr, for a programmed number of MCUs per frame.
- For each block it selects the quantization table, issues a one-cycle start and waits for done.
- It then hands a component tag to the downstream entropy stage and waits for acceptance before issuing the next block.
- Sits between the frame controller and the quantizer/entropy coder pair.

Parameters:
- Y_BLOCKS, 4, luma blocks per MCU (1..15).
- MCU_W, 16, width of the MCU counters.
- TIMEOUT, 1023, maximum cycles to wait for quant_done before flagging an error (≥70).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- enable  in  1  global enable; when low, no new quant_start is issued.
- abort  in  1  synchronous abort to IDLE.
- frame_start  in  1  one-cycle pulse that begins a frame.
- mcus_per_frame  in  MCU_W  MCUs in the frame; sampled on frame_start.
- quant_busy  in  1  quantizer busy status.
- quant_done  in  1  quantizer one-cycle done pulse.
- quant_start  out  1  one-cycle start pulse to the quantizer.
- quant_table_select  out  2  table code: 0=Y, 1=Cb, 2=Cr.
- blk_valid  out  1  quantized block available downstream.
- blk_ready  in  1  downstream accepts the block.
- blk_comp  out  2  component tag of the block: 0=Y, 1=Cb, 2=Cr.
- blk_last  out  1  last block of the frame (qualified by blk_valid).
- mcu_count  out  MCU_W  number of MCUs completed in the current frame.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when the frame completes.
- timeout_err  out  1  sticky error flag.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs 0; internal blk_idx, mcu_count and timer cleared.
- States: IDLE, ISSUE, WAIT_DONE, DELIVER, FRAME_END, ERROR.

IDLE
- frame_start=1 and mcus_per_frame≠0: latch mcus_per_frame; clear mcu_count, blk_idx and timeout_err; go to ISSUE.
- frame_start=1 and mcus_per_frame=0: pulse frame_done next cycle; stay in IDLE.
- frame_start=0: ignored otherwise.

ISSUE
- quant_table_select is driven from blk_idx: blk_idx<Y_BLOCKS → 0; blk_idx=Y_BLOCKS → 1; blk_idx=Y_BLOCKS+1 → 2.
- When enable=1 and quant_busy=0: register quant_start=1 for exactly one cycle, clear the timer, go to WAIT_DONE.
- Otherwise wait in ISSUE.

WAIT_DONE
- quant_table_select is held stable.
- quant_done is ignored in the same cycle quant_start is high.
- quant_done=1 → DELIVER.
- Timer increments each cycle; when it reaches TIMEOUT → ERROR.

DELIVER
- blk_valid=1 with blk_comp; blk_last=1 when mcu_count=latched−1 and blk_idx=Y_BLOCKS+1.
- blk_valid, blk_comp and blk_last are held until blk_ready=1; blk_ready=1 in the first DELIVER cycle completes in 1 cycle.
- On acceptance, blk_valid drops the next cycle and:
  - if blk_idx=Y_BLOCKS+1: blk_idx←0, mcu_count+1; if the new count equals latched → FRAME_END, else → ISSUE.
  - else: blk_idx+1 → ISSUE.

FRAME_END
- Pulse frame_done for one cycle, then go to IDLE.
- mcu_count holds its final value until the next frame_start.

ERROR
- timeout_err=1 (sticky); busy stays 1; no further quant_start.
- Exit only on abort or reset; abort returns to IDLE with timeout_err still 1 until the next accepted frame_start.

Boundary conditions
- abort in any state: next cycle state=IDLE; blk_valid=0 and quant_start=0; no frame_done.
- abort has priority over every other event.
- frame_start outside IDLE is ignored.
- enable=0 only stalls ISSUE; a block already started still completes and is delivered.
- Latency: frame_start → quant_start = 2 cycles when quant_busy=0.
- Throughput: 3 cycles of overhead per block in addition to quantizer latency (ISSUE, start cycle, DELIVER with immediate ready).
- Counter wrap is impossible: mcu_count never exceeds the latched value.

Test Plan:
1. Default params, mcus_per_frame=2, quantizer model with done 66 cycles after start, blk_ready tied 1 → 12 quant_starts.
   - quant_table_select sequence 0,0,0,0,1,2,0,0,0,0,1,2.
   - blk_last only on block 12; frame_done one pulse; mcu_count=2.
2. mcus_per_frame=1, blk_ready low 10 cycles on block 3 → blk_valid/blk_comp=0 held 10 cycles; no quant_start during the stall; frame completes with 6 blocks.
3. Quantizer never asserts done, TIMEOUT=1023 → timeout_err=1 exactly 1023 cycles after the first quant_start; busy=1; no further start.
   - Then abort → IDLE; frame_start clears timeout_err.
4. mcus_per_frame=0 with frame_start → busy stays 0; frame_done pulse one cycle later; no quant_start.
5. enable=0 while in ISSUE for 5 cycles, plus quant_busy=1 at the first issue → quant_start is delayed until both are cleared; frame_start arriving mid-frame is ignored.
6. rst_n asserted asynchronously mid-WAIT_DONE, and abort during DELIVER → all outputs 0 immediately on reset, 1 cycle after abort; a new frame then runs correctly from blk_idx=0.

Source files
------------

// File: rtl/mcu_quant_sequencer_if.sv
// Quantizer / entropy-stage handshake bundle for the MCU sequencer.
// master = sequencer side, slave = quantizer and entropy coder side.
interface mcu_quant_sequencer_if;
   logic       quant_start;
   logic [1:0] quant_table_select;
   logic       quant_busy;
   logic       quant_done;
   logic       blk_valid;
   logic       blk_ready;
   logic [1:0] blk_comp;
   logic       blk_last;

   modport master (
      output quant_start, quant_table_select,
      output blk_valid, blk_comp, blk_last,
      input  quant_busy, quant_done, blk_ready
   );

   modport slave (
      input  quant_start, quant_table_select,
      input  blk_valid, blk_comp, blk_last,
      output quant_busy, quant_done, blk_ready
   );
endinterface

// File: rtl/mcu_quant_sequencer.sv
// Steps the shared quantizer through 4:2:0 MCUs (Y0..Yn-1, Cb, Cr)
// and hands each block's component tag to the entropy stage.
module mcu_quant_sequencer #(
   parameter int Y_BLOCKS = 4,
   parameter int MCU_W    = 16,
   parameter int TIMEOUT  = 1023
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             abort,
   input  logic             frame_start,
   input  logic [MCU_W-1:0] mcus_per_frame,
   mcu_quant_sequencer_if.master bus,
   output logic [MCU_W-1:0] mcu_count,
   output logic             busy,
   output logic             frame_done,
   output logic             timeout_err
);

   localparam int IW = 5;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] IDX_CB = IW'(Y_BLOCKS);
   localparam logic [IW-1:0] IDX_CR = IW'(Y_BLOCKS + 1);
   localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT_DONE, DELIVER, FRAME_END, ERROR
   } state_t;

   state_t           state, state_n;
   logic [IW-1:0]    blk_idx, idx_n;
   logic [MCU_W-1:0] cnt_n, mcu_lat, lat_n;
   logic [TW-1:0]    timer, tmr_n;
   logic             start_q, start_n;
   logic             err_n;
   logic             zero_done, zdone_n;
   logic [1:0]       comp;

   // Component of the current block from its position inside the MCU
   always_comb begin
      comp = 2'd0;
      unique case (1'b1)
         (blk_idx == IDX_CR): comp = 2'd2;
         (blk_idx == IDX_CB): comp = 2'd1;
         default:             comp = 2'd0;
      endcase
   end

   // Next state and next datapath values; abort overrides everything
   always_comb begin
      state_n = state;
      idx_n   = blk_idx;
      cnt_n   = mcu_count;
      lat_n   = mcu_lat;
      tmr_n   = timer;
      start_n = 1'b0;
      err_n   = timeout_err;
      zdone_n = 1'b0;
      if (abort) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (frame_start) begin
                  if (mcus_per_frame != '0) begin
                     lat_n   = mcus_per_frame;
                     cnt_n   = '0;
                     idx_n   = '0;
                     err_n   = 1'b0;
                     state_n = ISSUE;
                  end else begin
                     zdone_n = 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (enable && !bus.quant_busy) begin
                  start_n = 1'b1;
                  tmr_n   = '0;
                  state_n = WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (bus.quant_done && !start_q) begin
                  state_n = DELIVER;
               end else if (timer == TMAX) begin
                  err_n   = 1'b1;
                  state_n = ERROR;
               end else begin
                  tmr_n = timer + 1'b1;
               end
            end
            DELIVER: begin
               if (bus.blk_ready) begin
                  if (blk_idx == IDX_CR) begin
                     idx_n   = '0;
                     cnt_n   = mcu_count + 1'b1;
                     state_n = (cnt_n == mcu_lat) ? FRAME_END : ISSUE;
                  end else begin
                     idx_n   = blk_idx + 1'b1;
                     state_n = ISSUE;
                  end
               end
            end
            FRAME_END: state_n = IDLE;
            ERROR:     err_n   = 1'b1;
            default:   state_n = IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Block index, MCU counters, timer and pulse/flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_idx     <= '0;
         mcu_count   <= '0;
         mcu_lat     <= '0;
         timer       <= '0;
         start_q     <= 1'b0;
         timeout_err <= 1'b0;
         zero_done   <= 1'b0;
      end else begin
         blk_idx     <= idx_n;
         mcu_count   <= cnt_n;
         mcu_lat     <= lat_n;
         timer       <= tmr_n;
         start_q     <= start_n;
         timeout_err <= err_n;
         zero_done   <= zdone_n;
      end
   end

   assign busy       = (state != IDLE);
   assign frame_done = (state == FRAME_END) | zero_done;

   assign bus.quant_start        = start_q;
   assign bus.quant_table_select =
      (state == ISSUE || state == WAIT_DONE) ? comp : 2'd0;
   assign bus.blk_valid = (state == DELIVER);
   assign bus.blk_comp  = (state == DELIVER) ? comp : 2'd0;
   assign bus.blk_last  = (state == DELIVER) &&
                          (blk_idx == IDX_CR) &&
                          (mcu_count == mcu_lat - 1'b1);

endmodule
